// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller for a 512-bit Montgomery exponentiation.
// Sequences an external Montgomery multiplier and converts the accumulator back to normal form.
module mont_exp_ctrl (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [511:0] in_x,
    input  logic [511:0] in_r,
    input  logic [511:0] in_e,
    input  logic [9:0]   in_elen,
    input  logic [511:0] in_m,
    output logic [511:0] result,
    output logic         done,
    output logic         mm_start,
    output logic [511:0] mm_in_a,
    output logic [511:0] mm_in_b,
    output logic [511:0] mm_in_m,
    input  logic [511:0] mm_result,
    input  logic         mm_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SQ    = 3'd1,
        ST_SQ_W  = 3'd2,
        ST_MUL   = 3'd3,
        ST_MUL_W = 3'd4,
        ST_FIN   = 3'd5,
        ST_FIN_W = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    state_t       state_r;
    state_t       state_nx_s;

    logic [511:0] a_r;
    logic [511:0] x_r;
    logic [511:0] e_r;
    logic [8:0]   i_r;
    logic [511:0] result_r;
    logic         done_r;
    logic         mm_start_r;
    logic [511:0] mm_in_a_r;
    logic [511:0] mm_in_b_r;
    logic [511:0] mm_in_m_r;

    logic [9:0]   elen_clamp_s;
    logic [8:0]   i_init_s;
    logic         accept_s;
    logic         a_from_mm_s;
    logic         issue_sq_s;
    logic         issue_mul_s;
    logic         issue_fin_s;
    logic         dec_i_s;
    logic         ld_result_s;
    logic [511:0] a_nx_s;

    // Exponent length saturation and the starting bit index.
    always_comb begin
        elen_clamp_s = in_elen;
        i_init_s     = 9'd0;
        if (in_elen > 10'd512) begin
            elen_clamp_s = 10'd512;
        end else begin
            elen_clamp_s = in_elen;
        end
        if (elen_clamp_s == 10'd0) begin
            i_init_s = 9'd0;
        end else begin
            // elen=512 wraps [8:0]=0 to 511, which is the intended top index
            i_init_s = elen_clamp_s[8:0] - 9'd1;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nx_s  = state_r;
        accept_s    = 1'b0;
        a_from_mm_s = 1'b0;
        issue_sq_s  = 1'b0;
        issue_mul_s = 1'b0;
        issue_fin_s = 1'b0;
        dec_i_s     = 1'b0;
        ld_result_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if (elen_clamp_s != 10'd0) begin
                        state_nx_s = ST_SQ;
                        issue_sq_s = 1'b1;
                    end else begin
                        state_nx_s  = ST_FIN;
                        issue_fin_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SQ: begin
                state_nx_s = ST_SQ_W;
            end
            ST_SQ_W: begin
                if (mm_done) begin
                    a_from_mm_s = 1'b1;
                    if (e_r[i_r]) begin
                        state_nx_s  = ST_MUL;
                        issue_mul_s = 1'b1;
                    end else if (i_r != 9'd0) begin
                        state_nx_s = ST_SQ;
                        issue_sq_s = 1'b1;
                        dec_i_s    = 1'b1;
                    end else begin
                        state_nx_s  = ST_FIN;
                        issue_fin_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_SQ_W;
                end
            end
            ST_MUL: begin
                state_nx_s = ST_MUL_W;
            end
            ST_MUL_W: begin
                if (mm_done) begin
                    a_from_mm_s = 1'b1;
                    if (i_r != 9'd0) begin
                        state_nx_s = ST_SQ;
                        issue_sq_s = 1'b1;
                        dec_i_s    = 1'b1;
                    end else begin
                        state_nx_s  = ST_FIN;
                        issue_fin_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_MUL_W;
                end
            end
            ST_FIN: begin
                state_nx_s = ST_FIN_W;
            end
            ST_FIN_W: begin
                if (mm_done) begin
                    ld_result_s = 1'b1;
                    state_nx_s  = ST_DONE;
                end else begin
                    state_nx_s = ST_FIN_W;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Accumulator value after this edge; it is also the A operand of any issued multiply.
    always_comb begin
        a_nx_s = a_r;
        if (accept_s) begin
            a_nx_s = in_r;
        end else if (a_from_mm_s) begin
            a_nx_s = mm_result;
        end else begin
            a_nx_s = a_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Captured operands, accumulator and bit index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_r       <= 512'd0;
            x_r       <= 512'd0;
            e_r       <= 512'd0;
            i_r       <= 9'd0;
            mm_in_m_r <= 512'd0;
        end else begin
            a_r <= a_nx_s;
            if (accept_s) begin
                x_r       <= in_x;
                e_r       <= in_e;
                mm_in_m_r <= in_m;
                i_r       <= i_init_s;
            end else if (dec_i_s) begin
                i_r <= i_r - 9'd1;
            end
        end
    end

    // Multiplier request: operands are loaded together with the start pulse and then held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mm_start_r <= 1'b0;
            mm_in_a_r  <= 512'd0;
            mm_in_b_r  <= 512'd0;
        end else begin
            mm_start_r <= issue_sq_s | issue_mul_s | issue_fin_s;
            if (issue_sq_s) begin
                mm_in_a_r <= a_nx_s;
                mm_in_b_r <= a_nx_s;
            end else if (issue_mul_s) begin
                mm_in_a_r <= a_nx_s;
                mm_in_b_r <= x_r;
            end else if (issue_fin_s) begin
                mm_in_a_r <= a_nx_s;
                mm_in_b_r <= 512'd1;
            end
        end
    end

    // Final product and the completion pulse, raised in the cycle spent in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_r <= 512'd0;
            done_r   <= 1'b0;
        end else begin
            done_r <= ld_result_s;
            if (ld_result_s) begin
                result_r <= mm_result;
            end
        end
    end

    assign result   = result_r;
    assign done     = done_r;
    assign mm_start = mm_start_r;
    assign mm_in_a  = mm_in_a_r;
    assign mm_in_b  = mm_in_b_r;
    assign mm_in_m  = mm_in_m_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a fixed-latency Montgomery multiplier model.
module tb_mont_exp_ctrl;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [511:0] in_x, in_r, in_e, in_m;
    logic [9:0]   in_elen;
    logic [511:0] result;
    logic         done;
    logic         mm_start;
    logic [511:0] mm_in_a, mm_in_b, mm_in_m;
    logic [511:0] mm_result = 512'd0;
    logic         mm_done = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int mm_start_cnt = 0;
    int done_cnt     = 0;
    int lat_cnt      = 0;
    logic [511:0] pend = 512'd0;

    mont_exp_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x      (in_x),
        .in_r      (in_r),
        .in_e      (in_e),
        .in_elen   (in_elen),
        .in_m      (in_m),
        .result    (result),
        .done      (done),
        .mm_start  (mm_start),
        .mm_in_a   (mm_in_a),
        .mm_in_b   (mm_in_b),
        .mm_in_m   (mm_in_m),
        .mm_result (mm_result),
        .mm_done   (mm_done)
    );

    always #5 clk = ~clk;

    // a*b*2^-512 mod m, bit-serial
    function automatic logic [511:0] mont(input logic [511:0] a, input logic [511:0] b,
                                          input logic [511:0] m);
        logic [513:0] t;
        t = 514'd0;
        for (int k = 0; k < 512; k++) begin
            if (a[k]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[511:0];
    endfunction

    // a*b mod m by shift-and-add (a < m)
    function automatic logic [511:0] mulmod(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m);
        logic [512:0] r;
        r = 513'd0;
        for (int j = 511; j >= 0; j--) begin
            r = r << 1;
            if (r >= {1'b0, m}) r = r - {1'b0, m};
            if (b[j]) begin
                r = r + {1'b0, a};
                if (r >= {1'b0, m}) r = r - {1'b0, m};
            end
        end
        return r[511:0];
    endfunction

    function automatic logic [511:0] r_mod(input logic [511:0] m);
        logic [512:0] r;
        r = 513'd1;
        for (int k = 0; k < 512; k++) begin
            r = r << 1;
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end
        return r[511:0];
    endfunction

    // right-to-left binary exponentiation in normal form
    function automatic logic [511:0] modexp(input logic [511:0] b, input logic [511:0] e,
                                            input logic [511:0] m);
        logic [511:0] res, base;
        res  = 512'd1;
        base = b;
        for (int k = 0; k < 512; k++) begin
            if (e[k]) res = mulmod(res, base, m);
            base = mulmod(base, base, m);
        end
        return res;
    endfunction

    // Multiplier model: product appears with mm_done LAT cycles after the mm_start cycle.
    always @(posedge clk) begin
        mm_done <= 1'b0;
        if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                mm_done   <= 1'b1;
                mm_result <= pend;
            end
        end
        if (mm_start) begin
            lat_cnt <= LAT - 1;
            pend    <= mont(mm_in_a, mm_in_b, mm_in_m);
        end
    end

    // Event counters.
    always @(posedge clk) begin
        if (mm_start) mm_start_cnt <= mm_start_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_ops(input logic [511:0] x, input logic [511:0] e,
                            input logic [511:0] m, input logic [9:0] elen);
        logic [511:0] rm;
        rm      = r_mod(m);
        in_r    = rm;
        in_x    = mulmod(x, rm, m);
        in_e    = e;
        in_m    = m;
        in_elen = elen;
    endtask

    task automatic wait_done(input string tag, input int budget, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq({tag, "_timeout"}, 512'd0, 512'd1);
    endtask

    task automatic finish_checks(input string tag, input int p0, input int d0,
                                 input logic [511:0] exp_res, input int exp_pulses,
                                 input logic [511:0] m);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_mm_in_m"}, mm_in_m, m);
        check_eq({tag, "_pulses"}, 512'(mm_start_cnt - p0), 512'(exp_pulses));
        @(negedge clk);
        check_eq({tag, "_done_low"}, 512'(done), 512'd0);
        check_eq({tag, "_done_cycles"}, 512'(done_cnt - d0), 512'd1);
        check_eq({tag, "_held"}, result, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [511:0] x, input logic [511:0] e,
                          input logic [511:0] m, input logic [9:0] elen,
                          input logic [511:0] exp_res, input int exp_pulses, input int budget);
        int p0, d0;
        logic ok;
        @(negedge clk);
        load_ops(x, e, m, elen);
        p0    = mm_start_cnt;
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, budget, ok);
        if (ok) finish_checks(tag, p0, d0, exp_res, exp_pulses, m);
    endtask

    initial begin
        int   p0, d0;
        logic ok;
        logic [511:0] m_big;
        logic [511:0] big_ref;

        resetn  = 1'b0;
        start   = 1'b0;
        in_x    = 512'd0;
        in_r    = 512'd0;
        in_e    = 512'd0;
        in_m    = 512'd0;
        in_elen = 10'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_mm_start", 512'(mm_start), 512'd0);
        check_eq("rst_done", 512'(done), 512'd0);
        check_eq("rst_result", result, 512'd0);
        check_eq("rst_mm_in_a", mm_in_a, 512'd0);
        check_eq("rst_mm_in_b", mm_in_b, 512'd0);
        check_eq("rst_mm_in_m", mm_in_m, 512'd0);
        check_eq("rst_a", dut.a_r, 512'd0);
        check_eq("rst_i", 512'(dut.i_r), 512'd0);
        resetn = 1'b1;

        // 2^5 mod 13 = 6; 3 squares + 2 multiplies + final
        run_op("basic", 512'd2, 512'd5, 512'd13, 10'd3, 512'd6, 6, 200);
        // elen=0 gives 1 via the single FIN multiply
        run_op("elen0", 512'd7, 512'd0, 512'd13, 10'd0, 512'd1, 1, 100);
        // elen clamped to 512, e=1 -> x mod m
        run_op("elen_clamp", 512'd5, 512'd1, 512'd13, 10'd1023, 512'd5, 514, 7000);

        // start re-pulsed while waiting on the first square
        @(negedge clk);
        load_ops(512'd2, 512'd5, 512'd13, 10'd3);
        p0    = mm_start_cnt;
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && mm_start_cnt == p0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        load_ops(512'd9, 512'd3, 512'd11, 10'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart", 200, ok);
        if (ok) finish_checks("restart", p0, d0, 512'd6, 6, 512'd13);

        // reset dropped in MUL_W, multiplier still answers afterwards
        @(negedge clk);
        load_ops(512'd2, 512'd5, 512'd13, 10'd3);
        p0    = mm_start_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60 && mm_start_cnt < p0 + 2; c++) @(negedge clk);
        check_eq("abort_reached_mul", 512'(mm_start_cnt - p0), 512'd2);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        p0 = mm_start_cnt;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        check_eq("abort_mm_start", 512'(mm_start_cnt - p0), 512'd0);
        check_eq("abort_done", 512'(done_cnt - d0), 512'd0);
        check_eq("abort_a", dut.a_r, 512'd0);
        run_op("after_abort", 512'd2, 512'd5, 512'd13, 10'd3, 512'd6, 6, 200);

        // m = 2^511+1, e = 2^512-1
        m_big   = 512'd1;
        m_big   = (m_big << 511) | 512'd1;
        big_ref = modexp(512'd3, {512{1'b1}}, m_big);
        run_op("big", 512'd3, {512{1'b1}}, m_big, 10'd512, big_ref, 1025, 14000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
